distance_seq: RTL and testbench

- Sequential, parametrised distance engine for the point-processing datapath. Computes the distance between two points (x1,y1) and (x2,y2) using a valid/ready handshake.
- Four modes are selectable per transaction: Euclidean, Manhattan, squared Euclidean and Chebyshev.
- Euclidean mode uses an iterative integer Newton square root. Iterations are seeded with the Manhattan distance and driven by a shared bit-serial divider. Iteration stops early on convergence, so the result is exactly floor(sqrt) when convergence is reached.

---
 rtl/distance_seq_if.sv | 33 +++
 rtl/distance_seq.sv | 140 ++++++++++++++
 tb/tb_distance_seq.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/distance_seq_if.sv
// Purpose: handshake bundle for distance_seq; request side (in_*) and result side (out_*).
// Ports: in_valid/in_ready + x1,y1,x2,y2,mode request; out_valid/out_ready + res,res_exact,res_iters result.
// Backpressure: valid/ready on both sides; the slave modport is the distance engine, the master drives requests.
interface distance_seq_if #(
    parameter int COORD_W  = 8,
    parameter int RES_W    = 32,
    parameter int MAX_ITER = 4
);
    localparam int IT_W = $clog2(MAX_ITER + 1);

    logic               in_valid;
    logic               in_ready;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic [1:0]         mode;
    logic               out_valid;
    logic               out_ready;
    logic [RES_W-1:0]   res;
    logic               res_exact;
    logic [IT_W-1:0]    res_iters;

    modport master (
        output in_valid, x1, y1, x2, y2, mode, out_ready,
        input  in_ready, out_valid, res, res_exact, res_iters
    );

    modport slave (
        input  in_valid, x1, y1, x2, y2, mode, out_ready,
        output in_ready, out_valid, res, res_exact, res_iters
    );
endinterface

// File: rtl/distance_seq.sv
// Purpose: distance engine (Euclidean via Newton sqrt, Manhattan, squared Euclidean, Chebyshev), one transaction in flight.
// Latency: 1 cycle for non-Euclidean or zero distance; 1 + k*(2*COORD_W+2) cycles for k Newton iterations.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Ports: clk, rst_n, io (slave modport).
module distance_seq #(
    parameter int COORD_W  = 8,
    parameter int RES_W    = 32,
    parameter int MAX_ITER = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    distance_seq_if.slave  io
);
    localparam int SQ_W  = 2 * COORD_W + 1;
    localparam int IT_W  = $clog2(MAX_ITER + 1);
    localparam int CNT_W = $clog2(SQ_W);

    typedef enum logic [2:0] {IDLE, CALC, DIV, UPD, DONE} state_t;
    state_t state, state_nxt;

    logic [COORD_W-1:0] xa, ya, xb, yb;
    logic [1:0]         mode_r;
    logic [SQ_W-1:0]    sq_r;
    logic [SQ_W-1:0]    cur;
    logic [SQ_W-1:0]    quo;     // holds the dividend, replaced bit by bit by the quotient
    logic [SQ_W-1:0]    rem;
    logic [CNT_W-1:0]   cnt;
    logic [IT_W-1:0]    k;
    logic [RES_W-1:0]   res_r;
    logic               exact_r;
    logic [IT_W-1:0]    iters_r;

    logic [COORD_W-1:0] dx, dy, cheb_c;
    logic [SQ_W-1:0]    dx_w, dy_w, sq_c;
    logic [COORD_W:0]   mh_c;
    logic [SQ_W:0]      rem_sh;
    logic               fits;
    logic [SQ_W-1:0]    rem_sub;
    logic [SQ_W:0]      sum_c;
    logic [SQ_W-1:0]    nxt_c;
    logic [IT_W-1:0]    k_inc;
    logic               conv, last_iter, cnt_last;
    logic [RES_W-1:0]   mode_res;

    always_comb begin
        dx       = (xa >= xb) ? (xa - xb) : (xb - xa);
        dy       = (ya >= yb) ? (ya - yb) : (yb - ya);
        dx_w     = SQ_W'(dx);
        dy_w     = SQ_W'(dy);
        sq_c     = dx_w * dx_w + dy_w * dy_w;
        mh_c     = {1'b0, dx} + {1'b0, dy};
        cheb_c   = (dx >= dy) ? dx : dy;
        // restoring division step: shift in next dividend bit, subtract if it fits
        rem_sh   = {rem, quo[SQ_W-1]};
        fits     = rem_sh >= {1'b0, cur};
        rem_sub  = rem_sh[SQ_W-1:0] - cur;
        // extra sum bit keeps (cur + q) from wrapping before the halving
        sum_c    = {1'b0, cur} + {1'b0, quo};
        nxt_c    = SQ_W'(sum_c >> 1);
        k_inc    = k + IT_W'(1);
        conv     = nxt_c >= cur;
        last_iter = k_inc == IT_W'(MAX_ITER);
        cnt_last = cnt == CNT_W'(SQ_W - 1);
        mode_res = '0;
        case (mode_r)
            2'd1:    mode_res = RES_W'(mh_c);
            2'd2:    mode_res = RES_W'(sq_c);
            default: mode_res = RES_W'(cheb_c);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (io.in_valid) state_nxt = CALC;
            CALC: state_nxt = (mode_r != 2'd0 || mh_c == '0) ? DONE : DIV;
            DIV:  if (cnt_last) state_nxt = UPD;
            UPD:  state_nxt = (conv || last_iter) ? DONE : DIV;
            DONE: if (io.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xa <= '0; ya <= '0; xb <= '0; yb <= '0; mode_r <= '0;
            sq_r <= '0; cur <= '0; quo <= '0; rem <= '0; cnt <= '0; k <= '0;
            res_r <= '0; exact_r <= 1'b0; iters_r <= '0;
        end else begin
            case (state)
                IDLE: if (io.in_valid) begin
                    xa <= io.x1; ya <= io.y1; xb <= io.x2; yb <= io.y2;
                    mode_r <= io.mode;
                end
                CALC: begin
                    sq_r <= sq_c;
                    cur  <= SQ_W'(mh_c);
                    quo  <= sq_c;
                    rem  <= '0;
                    cnt  <= '0;
                    k    <= '0;
                    if (mode_r != 2'd0) begin
                        res_r <= mode_res; exact_r <= 1'b1; iters_r <= '0;
                    end else if (mh_c == '0) begin
                        res_r <= '0; exact_r <= 1'b1; iters_r <= '0;
                    end
                end
                DIV: begin
                    rem <= fits ? rem_sub : rem_sh[SQ_W-1:0];
                    quo <= {quo[SQ_W-2:0], fits};
                    cnt <= cnt + CNT_W'(1);
                end
                UPD: begin
                    k <= k_inc;
                    if (conv) begin
                        res_r <= RES_W'(cur); exact_r <= 1'b1; iters_r <= k_inc;
                    end else if (last_iter) begin
                        res_r <= RES_W'(nxt_c); exact_r <= 1'b0; iters_r <= k_inc;
                    end else begin
                        cur <= nxt_c;
                        quo <= sq_r;
                        rem <= '0;
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.res       = res_r;
    assign io.res_exact = exact_r;
    assign io.res_iters = iters_r;
endmodule

// File: tb/tb_distance_seq.sv
// Purpose: randomized + directed bench for distance_seq against a plain-arithmetic model.
// Latency: checks first-valid latency per transaction; backpressure via random/held out_ready.
// Backpressure: in_valid noise while busy must never be captured.
module tb_distance_seq;
    localparam int CW  = 8;
    localparam int RW  = 32;
    localparam int MI  = 4;
    localparam int SQW = 2 * CW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    distance_seq_if #(.COORD_W(CW), .RES_W(RW), .MAX_ITER(MI)) bus ();
    distance_seq_if #(.COORD_W(CW), .RES_W(RW), .MAX_ITER(3))  bus3 ();

    distance_seq #(.COORD_W(CW), .RES_W(RW), .MAX_ITER(MI)) dut  (.clk(clk), .rst_n(rst_n), .io(bus));
    distance_seq #(.COORD_W(CW), .RES_W(RW), .MAX_ITER(3))  dut3 (.clk(clk), .rst_n(rst_n), .io(bus3));

    typedef struct {
        longint r;
        int     ex;
        int     it;
        int     lat;
        int     acc;
        bit     seen;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic longint sqd(input int a, input int b, input int c, input int d);
        longint dx, dy;
        dx = (a > c) ? a - c : c - a;
        dy = (b > d) ? b - d : d - b;
        return dx * dx + dy * dy;
    endfunction

    function automatic longint isqrt(input longint v);
        longint s;
        s = 0;
        while ((s + 1) * (s + 1) <= v) s++;
        return s;
    endfunction

    // Newton on integers with plain division; stops when the estimate no longer decreases
    function automatic void model(input int a, input int b, input int c, input int d, input int m,
                                  input int maxit, output longint r, output int ex, output int it);
        longint dx, dy, sq, mh, cheb, cur, nx;
        dx = (a > c) ? a - c : c - a;
        dy = (b > d) ? b - d : d - b;
        sq = dx * dx + dy * dy;
        mh = dx + dy;
        cheb = (dx > dy) ? dx : dy;
        ex = 1;
        it = 0;
        r = 0;
        case (m)
            1: r = mh;
            2: r = sq;
            3: r = cheb;
            default: begin
                if (mh != 0) begin
                    cur = mh;
                    for (int k = 1; k <= maxit; k++) begin
                        nx = (cur + sq / cur) / 2;
                        it = k;
                        if (nx >= cur) begin
                            r = cur;
                            break;
                        end
                        if (k == maxit) begin
                            r = nx;
                            ex = 0;
                        end
                        cur = nx;
                    end
                end
            end
        endcase
    endfunction

    // single compare process: every cycle the result is presented
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                chk("res", bus.res, q[0].r);
                chk("res_exact", bus.res_exact, q[0].ex);
                chk("res_iters", bus.res_iters, q[0].it);
                chk("in_ready_while_done", bus.in_ready, 0);
                if (!q[0].seen) begin
                    chk("latency", cyc - q[0].acc - 1, q[0].lat);
                    q[0].seen = 1'b1;
                end
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic start(input int a, input int b, input int c, input int d, input int m);
        exp_t e;
        int n;
        model(a, b, c, d, m, MI, e.r, e.ex, e.it);
        e.lat = 1 + e.it * (SQW + 1);
        e.seen = 1'b0;
        if (m == 0 && e.ex == 1) chk("model_floor_sqrt", e.r, isqrt(sqd(a, b, c, d)));
        bus.x1 = CW'(a); bus.y1 = CW'(b); bus.x2 = CW'(c); bus.y2 = CW'(d);
        bus.mode = 2'(m);
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("accept_in_ready", bus.in_ready, 1);
        e.acc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            if (rnd) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.x1 = CW'($urandom); bus.y1 = CW'($urandom);
                bus.x2 = CW'($urandom); bus.y2 = CW'($urandom);
                bus.mode = 2'($urandom);
            end else begin
                bus.out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", q.size(), 0);
        q.delete();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        longint r;
        int ex, it, n, acc, a, b, c, d;

        bus.in_valid = 0; bus.out_ready = 1; bus.mode = 0;
        bus.x1 = 0; bus.y1 = 0; bus.x2 = 0; bus.y2 = 0;
        bus3.in_valid = 0; bus3.out_ready = 1; bus3.mode = 0;
        bus3.x1 = 0; bus3.y1 = 0; bus3.x2 = 0; bus3.y2 = 0;

        // pin the model to hand-computed values
        model(0, 0, 3, 4, 0, MI, r, ex, it);
        chk("pin_34_res", r, 5); chk("pin_34_exact", ex, 1); chk("pin_34_iters", it, 2);
        chk("pin_34_latency", 1 + it * (SQW + 1), 37);
        model(0, 0, 255, 255, 0, 4, r, ex, it);
        chk("pin_255_m4_res", r, 360); chk("pin_255_m4_exact", ex, 1); chk("pin_255_m4_iters", it, 4);
        model(0, 0, 255, 255, 0, 3, r, ex, it);
        chk("pin_255_m3_res", r, 360); chk("pin_255_m3_exact", ex, 0); chk("pin_255_m3_iters", it, 3);
        model(10, 20, 13, 16, 1, MI, r, ex, it); chk("pin_manhattan", r, 7);
        model(10, 20, 13, 16, 2, MI, r, ex, it); chk("pin_sq_euclid", r, 25);
        model(10, 20, 13, 16, 3, MI, r, ex, it); chk("pin_chebyshev", r, 4);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_res", bus.res, 0);
        chk("rst_res_exact", bus.res_exact, 0);
        chk("rst_res_iters", bus.res_iters, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed cases
        start(0, 0, 3, 4, 0);       drain(0);
        start(0, 0, 255, 255, 0);   drain(0);
        start(10, 20, 13, 16, 1);   drain(0);
        start(10, 20, 13, 16, 2);   drain(0);
        start(10, 20, 13, 16, 3);   drain(0);
        start(5, 5, 5, 5, 0);       drain(0);

        // iteration cap reached before convergence
        bus3.x2 = 8'd255; bus3.y2 = 8'd255; bus3.mode = 2'd0; bus3.in_valid = 1'b1;
        @(negedge clk);
        chk("cap_accept", bus3.in_ready, 1);
        acc = cyc;
        @(posedge clk);
        #1 bus3.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus3.out_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("cap_res", bus3.res, 360);
        chk("cap_exact", bus3.res_exact, 0);
        chk("cap_iters", bus3.res_iters, 3);
        chk("cap_latency", cyc - acc - 1, 1 + 3 * (SQW + 1));
        @(posedge clk);
        #1;

        // backpressure: result held, busy input ignored
        bus.out_ready = 1'b0;
        start(10, 20, 13, 16, 2);
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("bp_out_valid", bus.out_valid, 1);
        repeat (10) begin
            @(posedge clk);
            #1 bus.in_valid = 1'($urandom_range(0, 1));
            bus.x1 = CW'($urandom); bus.mode = 2'($urandom);
            @(negedge clk);
            chk("bp_in_ready_low", bus.in_ready, 0);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_after", bus.in_ready, 1);
        chk("bp_out_valid_after", bus.out_valid, 0);
        @(posedge clk);
        #1;
        start(0, 0, 3, 4, 0);
        drain(0);

        // reset in the middle of a division
        start(0, 0, 255, 255, 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_res", bus.res, 0);
        chk("midrst_iters", bus.res_iters, 0);
        q.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        start(0, 0, 3, 4, 0);
        drain(0);

        // random sweep with random backpressure and busy-time input noise
        for (int i = 0; i < 1500; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            c = int'($urandom_range(0, 255));
            d = int'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) begin
                c = a;
                d = b;
            end
            start(a, b, c, d, int'($urandom_range(0, 3)));
            drain(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
